// File: rtl/rr_index_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin index arbiter.
// MAX_HOLD is only consumed when RR_ARB_TIMEOUT_EN is defined.
package rr_arb_pkg;

  localparam int NUM_REQ  = 8;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 16;
  localparam int MAX_HOLD = 15;
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx2mask(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_index_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// slave = arbiter side, master = requester/driver side.
interface rr_index_arbiter_if;
  import rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req_i;
  logic               release_i;
  logic               gnt_valid_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic [CNT_W-1:0]   grant_cnt_o;
  logic               timeout_o;

  modport slave (
    input  req_i, release_i,
    output gnt_valid_o, gnt_idx_o, grant_cnt_o, timeout_o
  );

  modport master (
    output req_i, release_i,
    input  gnt_valid_o, gnt_idx_o, grant_cnt_o, timeout_o
  );

endinterface

// File: rtl/rr_index_arbiter_pick.sv
// Combinational rotated priority search: first set bit of (req & ~excl)
// starting at ptr and wrapping modulo NUM_REQ.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] excl_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   pos;

  // Walk from the lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    cand  = req_i & ~excl_i;
    any_o = |cand;
    idx_o = '0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = ptr_i + IDX_W'(k);
      if (cand[pos]) begin
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter for 8 requesters issuing a registered grant index held until release.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_index_arbiter
  import rr_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rr_index_arbiter_if.slave  bus
);

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic               gnt_valid_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [CNT_W-1:0]   grant_cnt_q;
  logic               timeout_q;
  logic               forced;
  logic               rel_eff;
  logic [NUM_REQ-1:0] excl;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

`ifdef RR_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0]  hold_q;

  // A real release in the same cycle wins, so no timeout pulse in that case.
  assign forced = (state_q == GRANT) && !bus.release_i &&
                  (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
  assign forced = 1'b0;
`endif

  // On release the search restarts just past the owner, and the owner sits out this cycle.
  always_comb begin
    rel_eff = (state_q == GRANT) && (bus.release_i || forced);
    ptr_d   = rel_eff ? gnt_idx_q + IDX_W'(1) : ptr_q;
    excl    = rel_eff ? idx2mask(gnt_idx_q) : '0;
  end

  rr_pick u_pick (
    .req_i  (bus.req_i),
    .ptr_i  (ptr_d),
    .excl_i (excl),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      grant_cnt_q <= '0;
      timeout_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q     <= GRANT;
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= pick_idx;
            grant_cnt_q <= sat_inc(grant_cnt_q);
`ifdef RR_ARB_TIMEOUT_EN
            hold_q      <= '0;
`endif
          end
        end
        GRANT: begin
          if (rel_eff) begin
            ptr_q     <= ptr_d;
            timeout_q <= forced;
            if (pick_any) begin
              gnt_idx_q   <= pick_idx;
              grant_cnt_q <= sat_inc(grant_cnt_q);
`ifdef RR_ARB_TIMEOUT_EN
              hold_q      <= '0;
`endif
            end else begin
              state_q     <= IDLE;
              gnt_valid_q <= 1'b0;
            end
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            hold_q <= hold_q + HOLD_W'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_valid_o = gnt_valid_q;
  assign bus.gnt_idx_o   = gnt_idx_q;
  assign bus.grant_cnt_o = grant_cnt_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter: vector table plus hand-written hold, reset,
// timeout (RR_ARB_TIMEOUT_EN) and saturation sequences.
module tb_rr_index_arbiter;
  import rr_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rr_index_arbiter_if bus ();

  rr_index_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  req;
    logic        rel;
    logic        v;
    logic [2:0]  idx;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [2:0] idx,
                         input logic [15:0] cnt);
    chk({nm, "_valid"}, 32'(bus.gnt_valid_o), 32'(v));
    chk({nm, "_idx"},   32'(bus.gnt_idx_o),   32'(idx));
    chk({nm, "_cnt"},   32'(bus.grant_cnt_o), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic rl);
    bus.req_i     = r;
    bus.release_i = rl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    drive(8'hFF, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    chk_out("rst", 1'b0, 3'd0, 16'd0);
    chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
    rst_n = 1'b1;

    // Full rotation, then pointer-wrap, exclusion and idle-release cases.
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 3'd0, 16'd1});
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{8'hFF, 1'b1, 1'b1, 3'(k % 8), 16'(k + 1)});
    tbl.push_back('{8'h20, 1'b1, 1'b1, 3'd5, 16'd10});
    tbl.push_back('{8'h05, 1'b1, 1'b1, 3'd0, 16'd11});
    tbl.push_back('{8'h05, 1'b1, 1'b1, 3'd2, 16'd12});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd2, 16'd12});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd2, 16'd12});

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].rel);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].cnt);
      chk($sformatf("vec%0d_timeout", i), 32'(bus.timeout_o), 32'd0);
    end

    // Owner drops req without releasing: grant must persist.
    drive(8'h08, 1'b0);
    step();
    chk_out("hold_start", 1'b1, 3'd3, 16'd13);
    drive(8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 1'b1, 3'd3, 16'd13);
    end

    // Released owner is excluded that cycle even with req still high.
    drive(8'h09, 1'b1);
    step();
    chk_out("excl_other", 1'b1, 3'd0, 16'd14);
    drive(8'h01, 1'b1);
    step();
    chk_out("excl_only_owner", 1'b0, 3'd0, 16'd14);
    drive(8'h01, 1'b0);
    step();
    chk_out("owner_again", 1'b1, 3'd0, 16'd15);

    // Asynchronous reset mid-grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 3'd0, 16'd0);
    step();
    rst_n = 1'b1;
    drive(8'h81, 1'b0);
    step();
    chk_out("post_rst", 1'b1, 3'd0, 16'd1);
    drive(8'h81, 1'b1);
    step();
    chk_out("post_rst_wrap", 1'b1, 3'd7, 16'd2);

    // Long hold without release: forced release only when the feature is built in.
    do_reset();
    drive(8'h06, 1'b0);
    step();
    chk_out("to_start", 1'b1, 3'd1, 16'd1);
    for (int i = 1; i <= 14; i++) begin
      step();
      chk($sformatf("to_hold%0d_idx", i), 32'(bus.gnt_idx_o), 32'd1);
      chk($sformatf("to_hold%0d_pulse", i), 32'(bus.timeout_o), 32'd0);
    end
    step();
`ifdef RR_ARB_TIMEOUT_EN
    chk_out("to_forced", 1'b1, 3'd2, 16'd2);
    chk("to_pulse", 32'(bus.timeout_o), 32'd1);
    step();
    chk("to_pulse_end", 32'(bus.timeout_o), 32'd0);
    chk_out("to_after", 1'b1, 3'd2, 16'd2);
`else
    chk_out("to_none", 1'b1, 3'd1, 16'd1);
    chk("to_no_pulse", 32'(bus.timeout_o), 32'd0);
    repeat (5) step();
    chk_out("to_none_late", 1'b1, 3'd1, 16'd1);
`endif

    // Counter saturation with back-to-back grants every cycle.
    drive(8'hFF, 1'b1);
    do_reset();
    repeat (65534) step();
    chk_out("sat_pre", 1'b1, 3'd5, 16'hFFFE);
    repeat (6) step();
    chk("sat_cnt", 32'(bus.grant_cnt_o), 32'h0000FFFF);
    chk("sat_valid", 32'(bus.gnt_valid_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
